// File: rtl/mist_video_out.sv
// Multi-source video output stage for the MiST VGA pins.
// This stage selects one core video stream and measures the polarity of each sync input.
// It expands colour depth to the pin width and enforces blanking.
// It drives H/V sync or composite sync to the pins.
// A source change waits for the new source's vsync so the monitor never sees a torn frame.

// Measures the polarity of one raw sync line by comparing time spent high and low.
module mist_sync_pol #(
  parameter int POL_W = 12
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pix_ce,
  input  logic sync_raw,
  output logic pol_low
);

  logic             sync_prev;
  logic [POL_W-1:0] hi_cnt;
  logic [POL_W-1:0] lo_cnt;

  // Count high/low time between rising edges; the longer level is the idle level.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_prev <= 1'b0;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      pol_low   <= 1'b0;
    end else if (pix_ce) begin
      sync_prev <= sync_raw;
      if (sync_raw && !sync_prev) begin
        pol_low <= (hi_cnt > lo_cnt);
        hi_cnt  <= '0;
        lo_cnt  <= '0;
      end else if (sync_raw) begin
        if (!(&hi_cnt)) hi_cnt <= hi_cnt + 1'b1;
      end else begin
        if (!(&lo_cnt)) lo_cnt <= lo_cnt + 1'b1;
      end
    end
  end

endmodule

module mist_video_out #(
  parameter int NUM_SRC    = 2,
  parameter int IN_DEPTH   = 6,
  parameter int OUT_DEPTH  = 6,
  parameter int SYNC_AND   = 0,
  parameter int POL_W      = 12,
  parameter int TO_W       = 20,
  parameter int SETTLE_FRM = 1,
  localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         pix_ce,
  input  logic [SW-1:0]                src_sel,
  input  logic                         csync_en,
  input  logic                         use_blanks,
  input  logic [NUM_SRC*IN_DEPTH-1:0]  R,
  input  logic [NUM_SRC*IN_DEPTH-1:0]  G,
  input  logic [NUM_SRC*IN_DEPTH-1:0]  B,
  input  logic [NUM_SRC-1:0]           HS,
  input  logic [NUM_SRC-1:0]           VS,
  input  logic [NUM_SRC-1:0]           HB,
  input  logic [NUM_SRC-1:0]           VB,
  output logic [OUT_DEPTH-1:0]         VGA_R,
  output logic [OUT_DEPTH-1:0]         VGA_G,
  output logic [OUT_DEPTH-1:0]         VGA_B,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic [SW-1:0]                active_src,
  output logic                         switching
);

  localparam logic [SW:0] NUM_SRC_W   = (SW + 1)'(NUM_SRC);
  localparam logic [1:0]  SETTLE_INIT = 2'(SETTLE_FRM);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SETTLE} state_t;

  state_t               state, state_nx;
  logic [SW-1:0]        target, target_nx, active_nx;
  logic [TO_W-1:0]      to_cnt, to_cnt_nx;
  logic [1:0]           frm, frm_nx;
  logic                 sel_valid;

  logic [NUM_SRC-1:0]   hs_pol_low, vs_pol_low;
  logic [NUM_SRC-1:0]   s_hs, s_vs, vs_prev, vs_start;

  logic [OUT_DEPTH-1:0] s1_r, s1_g, s1_b;
  logic                 s1_hs, s1_vs;
  logic [IN_DEPTH-1:0]  mux_r, mux_g, mux_b;
  logic                 mux_blank;

  // Replicate the input bits from the MSB downwards to fill the wider output channel.
  function automatic logic [OUT_DEPTH-1:0] expand(input logic [IN_DEPTH-1:0] c);
    logic [OUT_DEPTH-1:0] e;
    e = '0;
    for (int i = 0; i < OUT_DEPTH; i++)
      e[OUT_DEPTH-1-i] = c[IN_DEPTH-1-(i % IN_DEPTH)];
    return e;
  endfunction

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_pol
    mist_sync_pol #(.POL_W(POL_W)) u_hs_pol (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pix_ce  (pix_ce),
      .sync_raw(HS[n]),
      .pol_low (hs_pol_low[n])
    );
    mist_sync_pol #(.POL_W(POL_W)) u_vs_pol (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pix_ce  (pix_ce),
      .sync_raw(VS[n]),
      .pol_low (vs_pol_low[n])
    );
  end

  assign s_hs      = HS ^ hs_pol_low;
  assign s_vs      = VS ^ vs_pol_low;
  assign vs_start  = pix_ce ? (s_vs & ~vs_prev) : '0;
  assign sel_valid = ({1'b0, src_sel} < NUM_SRC_W);
  assign switching = (state != ST_IDLE);

  // Remember the previous normalised vsync level of every source to find frame starts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) vs_prev <= '0;
    else if (pix_ce) vs_prev <= s_vs;
  end

  // Select the active source's colour and blanking for the first pipeline stage.
  always_comb begin
    mux_r     = R[int'(active_src)*IN_DEPTH +: IN_DEPTH];
    mux_g     = G[int'(active_src)*IN_DEPTH +: IN_DEPTH];
    mux_b     = B[int'(active_src)*IN_DEPTH +: IN_DEPTH];
    mux_blank = (use_blanks & (HB[active_src] | VB[active_src])) | switching;
  end

  // Stage 1: expanded, blanked colour and normalised active-high sync.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
    end else begin
      s1_r  <= mux_blank ? '0 : expand(mux_r);
      s1_g  <= mux_blank ? '0 : expand(mux_g);
      s1_b  <= mux_blank ? '0 : expand(mux_b);
      s1_hs <= s_hs[active_src];
      s1_vs <= s_vs[active_src];
    end
  end

  // Stage 2: pin registers with active-low separate or composite sync.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_R <= s1_r;
      VGA_G <= s1_g;
      VGA_B <= s1_b;
      if (csync_en) begin
        VGA_HS <= (SYNC_AND != 0) ? ~(s1_hs | s1_vs) : ~(s1_hs ^ s1_vs);
        VGA_VS <= 1'b1;
      end else begin
        VGA_HS <= ~s1_hs;
        VGA_VS <= ~s1_vs;
      end
    end
  end

  // Switch FSM state and bookkeeping registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      target     <= '0;
      active_src <= '0;
      to_cnt     <= '0;
      frm        <= '0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      active_src <= active_nx;
      to_cnt     <= to_cnt_nx;
      frm        <= frm_nx;
    end
  end

  // Switch FSM decisions, taken only on pixel strobes.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    active_nx = active_src;
    to_cnt_nx = to_cnt;
    frm_nx    = frm;
    if (NUM_SRC > 1 && pix_ce) begin
      case (state)
        ST_IDLE: begin
          if (sel_valid && src_sel != active_src) begin
            target_nx = src_sel;
            to_cnt_nx = '0;
            state_nx  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (src_sel == active_src) begin
            state_nx = ST_IDLE;
          end else if (sel_valid && src_sel != target) begin
            target_nx = src_sel;
            to_cnt_nx = '0;
          end else if (vs_start[target] || (&to_cnt)) begin
            active_nx = target;
            frm_nx    = SETTLE_INIT;
            state_nx  = (SETTLE_FRM == 0) ? ST_IDLE : ST_SETTLE;
          end else begin
            to_cnt_nx = to_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (sel_valid && src_sel != active_src) begin
            target_nx = src_sel;
            to_cnt_nx = '0;
            state_nx  = ST_WAIT;
          end else if (vs_start[active_src]) begin
            if (frm <= 2'd1) begin
              frm_nx   = '0;
              state_nx = ST_IDLE;
            end else begin
              frm_nx = frm - 1'b1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule
